// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle between a requester and the serial adder.
// The requester drives start/sub/a/b; the adder answers with busy/done and the result fields.
interface serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, carry_out, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one full-adder cell walks a WIDTH-bit word LSB first,
// time-shared by operand shift registers, a carry flip-flop and a bit counter.
module serial_adder #(
  parameter int WIDTH = 16
) (
  input logic          clk,
  input logic          reset,
  serial_adder_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rs;
  logic             cy;
  logic             c_msb;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             ovf_r;
  logic             done_r;
  logic             s;
  logic             co;

  // The single full-adder cell shared by every bit position.
  always_comb begin
    s  = ra[0] ^ rb[0] ^ cy;
    co = (ra[0] & rb[0]) | (cy & (ra[0] ^ rb[0]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = RUN;
      RUN:     if (cnt == LAST_BIT) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Subtraction feeds ~b with a carry-in of 1, so the same cell forms a + ~b + 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      ra      <= '0;
      rb      <= '0;
      rs      <= '0;
      cy      <= 1'b0;
      c_msb   <= 1'b0;
      cnt     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            ra  <= bus.a;
            rb  <= bus.sub ? ~bus.b : bus.b;
            cy  <= bus.sub;
            cnt <= '0;
          end
        end
        RUN: begin
          rs  <= {s, rs[WIDTH-1:1]};
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          cy  <= co;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_BIT) c_msb <= cy;
        end
        DONE: begin
          sum_r   <= rs;
          carry_r <= cy;
          ovf_r   <= c_msb ^ cy;
        end
        default: ;
      endcase
    end
  end

  // done is registered so it rises together with the result it announces.
  always_comb begin
    bus.busy      = (state == RUN);
    bus.done      = done_r;
    bus.sum       = sum_r;
    bus.carry_out = carry_r;
    bus.overflow  = ovf_r;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases, handshake timing,
// reset behaviour and randomized operands against an arithmetic reference model.
module tb_serial_adder;

  localparam int W = 16;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [W-1:0] prev_sum;
  logic         prev_co;
  logic         prev_ov;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb;
    bus.sub   = tsub;
  endtask

  // Reference arithmetic on whole words: unsigned carry/no-borrow and sign-rule overflow.
  function automatic void refModel(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub,
                                   output logic [W-1:0] rsum, output logic rco, output logic rov);
    logic [W:0] wide;
    if (tsub) begin
      rsum = ta - tb;
      rco  = (ta >= tb);
      rov  = (ta[W-1] != tb[W-1]) && (rsum[W-1] != ta[W-1]);
    end else begin
      wide = {1'b0, ta} + {1'b0, tb};
      rsum = wide[W-1:0];
      rco  = wide[W];
      rov  = (ta[W-1] == tb[W-1]) && (rsum[W-1] != ta[W-1]);
    end
  endfunction

  // Called at a falling edge; returns at the falling edge where done is observed.
  task automatic runOp(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub,
                       input logic [W-1:0] esum, input logic eco, input logic eov,
                       input bit hold, input logic [W-1:0] ha, input logic [W-1:0] hb, input logic hsub);
    int busy_cnt;
    int lat;
    bit seen;
    applyStimulus(ta, tb, tsub);
    @(negedge clk);
    if (hold) applyStimulus(ha, hb, hsub);
    else bus.start = 1'b0;
    busy_cnt = 0;
    lat      = 0;
    seen     = 1'b0;
    for (int k = 1; k <= W + 10 && !seen; k++) begin
      if (k > 1) @(negedge clk);
      if (k == W / 2) begin
        checkOutput({tag, "_held_sum"}, 32'(bus.sum), 32'(prev_sum));
        checkOutput({tag, "_held_co"}, 32'(bus.carry_out), 32'(prev_co));
        checkOutput({tag, "_held_ov"}, 32'(bus.overflow), 32'(prev_ov));
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        seen = 1'b1;
        lat  = k - 1;
      end
    end
    checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(W + 1));
    checkOutput({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
    checkOutput({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_sum"}, 32'(bus.sum), 32'(esum));
    checkOutput({tag, "_carry_out"}, 32'(bus.carry_out), 32'(eco));
    checkOutput({tag, "_overflow"}, 32'(bus.overflow), 32'(eov));
    prev_sum = esum;
    prev_co  = eco;
    prev_ov  = eov;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rsub;
    logic [W-1:0] esum;
    logic         eco;
    logic         eov;

    errors    = 0;
    checks    = 0;
    prev_sum  = '0;
    prev_co   = 1'b0;
    prev_ov   = 1'b0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_sum", 32'(bus.sum), 32'd0);
    checkOutput("reset_co", 32'(bus.carry_out), 32'd0);
    checkOutput("reset_ov", 32'(bus.overflow), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] directed arithmetic cases");
    runOp("add_1_1", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checkOutput("done_single_pulse", 32'(bus.done), 32'd0);
    checkOutput("sum_kept_idle", 32'(bus.sum), 32'h0002);
    runOp("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    runOp("add_sovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    runOp("sub_5_7", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    runOp("sub_min", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);

    $display("[TB] start held during run");
    runOp("hold_first", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1, 16'hABCD, 16'h0F0F, 1'b1);
    runOp("hold_second", 16'hABCD, 16'h0F0F, 1'b1, 16'h9CBE, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checkOutput("hold_done_once", 32'(bus.done), 32'd0);

    $display("[TB] reset in the middle of a run");
    applyStimulus(16'h00FF, 16'h0F00, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_done", 32'(bus.done), 32'd0);
    checkOutput("midrst_sum", 32'(bus.sum), 32'd0);
    checkOutput("midrst_co", 32'(bus.carry_out), 32'd0);
    checkOutput("midrst_ov", 32'(bus.overflow), 32'd0);
    prev_sum = '0;
    prev_co  = 1'b0;
    prev_ov  = 1'b0;
    runOp("after_rst", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    $display("[TB] reset and start together");
    reset = 1'b1;
    applyStimulus(16'h0101, 16'h0202, 1'b0);
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    checkOutput("rst_start_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_start_sum", 32'(bus.sum), 32'd0);
    @(negedge clk);
    checkOutput("rst_start_idle", 32'(bus.busy), 32'd0);
    prev_sum = '0;
    prev_co  = 1'b0;
    prev_ov  = 1'b0;

    $display("[TB] randomized operations");
    for (int i = 0; i < 1000; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rsub = 1'($urandom_range(0, 1));
      if (i % 50 == 0) ra = {1'b1, {(W-1){1'b0}}};
      if (i % 50 == 1) rb = '1;
      refModel(ra, rb, rsub, esum, eco, eov);
      runOp("rand", ra, rb, rsub, esum, eco, eov, 1'b0, '0, '0, 1'b0);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
